// File: rtl/fsm_bist_pkg.sv
// Shared types, constants and step functions for the fsm_mur BIST engine.
package fsm_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRun,
        StDrain,
        StDone
    } bist_state_e;

    localparam int unsigned        MISR_W    = 16;
    localparam logic [MISR_W-1:0]  MISR_POLY = 16'h1021;
    // Feedback taps at bits 7,5,4,3 give a maximal-length (255) sequence.
    localparam logic [7:0]         LFSR_TAPS = 8'b1011_1000;

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                    input logic [3:0]        din);
        logic [MISR_W-1:0] shifted;
        shifted = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0);
        return shifted ^ {{(MISR_W-4){1'b0}}, din};
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fsm_bist_engine_misr.sv
// 16-bit multiple-input signature register compacting 4-bit FSM responses.
module bist_misr16
    import fsm_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [3:0]        data_i,
    output logic [MISR_W-1:0] sig_o
);

    logic [MISR_W-1:0] r_sig;

    // Signature register: clear wins over update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (clr_i) begin
            r_sig <= '0;
        end else if (en_i) begin
            r_sig <= misr_step(r_sig, data_i);
        end
    end

    assign sig_o = r_sig;

endmodule

// File: rtl/fsm_bist_engine.sv
// BIST initiator for fsm_mur: drives LFSR patterns, compacts state responses.
module fsm_bist_engine
    import fsm_bist_pkg::*;
#(
    parameter int unsigned       N_PATTERNS = 255,
    parameter logic [7:0]        LFSR_SEED  = 8'hA5,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bist_start_i,
    input  logic              bist_abort_i,
    input  logic [3:0]        func_sig_i,
    input  logic [3:0]        state_i,
    output logic [3:0]        sig_o,
    output logic              fsm_clr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [MISR_W-1:0] signature_o
);

    localparam int unsigned    CNT_W    = $clog2(N_PATTERNS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PATTERNS - 1);

    bist_state_e       r_state;
    bist_state_e       w_state_next;
    logic              r_start;
    logic [7:0]        r_lfsr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pass;
    logic              w_busy;
    logic              w_clr;
    logic              w_misr_en;
    logic [3:0]        w_pattern;
    logic [MISR_W-1:0] w_sig;

    // Start is captured once per idle/done period; abort or busy discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
        end else begin
            r_start <= bist_start_i & ~w_busy & ~bist_abort_i;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state controls; abort overrides every transition.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_clr        = 1'b0;
        w_misr_en    = 1'b0;
        w_pattern    = 4'h0;
        unique case (r_state)
            StIdle, StDone: begin
                if (r_start) w_state_next = StInit;
            end
            StInit: begin
                w_busy       = 1'b1;
                w_clr        = 1'b1;
                w_state_next = StRun;
            end
            StRun: begin
                w_busy       = 1'b1;
                w_misr_en    = 1'b1;
                w_pattern    = r_lfsr[3:0];
                if (r_cnt == CNT_LAST) w_state_next = StDrain;
            end
            StDrain: begin
                w_busy       = 1'b1;
                w_misr_en    = 1'b1;
                w_state_next = StDone;
            end
            default: w_state_next = StIdle;
        endcase
        if (bist_abort_i) w_state_next = StIdle;
    end

    // Pattern generator and pattern counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
            r_cnt  <= '0;
        end else if (r_state == StInit) begin
            r_lfsr <= LFSR_SEED;
            r_cnt  <= '0;
        end else if (r_state == StRun) begin
            r_lfsr <= lfsr_step(r_lfsr);
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Pass verdict sampled from the final signature as DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= 1'b0;
        end else if (bist_abort_i || (r_state == StInit)) begin
            r_pass <= 1'b0;
        end else if (r_state == StDrain) begin
            r_pass <= (misr_step(w_sig, state_i) == GOLDEN_SIG);
        end
    end

    bist_misr16 u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (w_clr),
        .en_i   (w_misr_en),
        .data_i (state_i),
        .sig_o  (w_sig)
    );

    assign sig_o       = w_busy ? w_pattern : func_sig_i;
    assign fsm_clr_o   = w_clr;
    assign busy_o      = w_busy;
    assign done_o      = (r_state == StDone);
    assign pass_o      = r_pass;
    assign signature_o = w_sig;

endmodule

// File: tb/tb_fsm_bist_engine.sv
// Directed bench for fsm_bist_engine with a behavioural fsm_mur stand-in.
module tb_fsm_bist_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] func = 4'h9;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  d_sig, d_state, a_sig, a_state, b_sig, b_state;
    logic        d_clr, d_busy, d_done, d_pass;
    logic        a_clr, a_busy, a_done, a_pass;
    logic        b_clr, b_busy, b_done, b_pass;
    logic [15:0] d_sigr, a_sigr, b_sigr;

    logic [15:0] full_ref;
    int          busy_gaps;
    int          clr_cycles;

    always #5 clk = ~clk;

    // Stand-in FSM: rotate state, xor in pattern unless pattern bit 2 is set.
    function automatic logic [3:0] fsm_next(input logic [3:0] s, input logic [3:0] p);
        return {s[2:0], s[3]} ^ (p[2] ? 4'h0 : {p[2:0], 1'b0});
    endfunction

    function automatic logic [15:0] mstep(input logic [15:0] m, input logic [3:0] d);
        return ({m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000)) ^ {12'h000, d};
    endfunction

    // Signature after the first 'upd' MISR updates of an n-pattern test.
    function automatic logic [15:0] ref_sig(input int n, input logic [7:0] seed, input int upd);
        logic [7:0]  l;
        logic [3:0]  f;
        logic [15:0] m;
        int          k;
        l = seed;
        f = 4'h0;
        m = 16'h0000;
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (k < upd) begin
                m = mstep(m, f);
                k++;
            end
            f = fsm_next(f, l[3:0]);
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        if (k < upd) m = mstep(m, f);
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      d_state <= 4'h0;
        else if (d_clr)  d_state <= 4'h0;
        else             d_state <= fsm_next(d_state, d_sig);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      a_state <= 4'h0;
        else if (a_clr)  a_state <= 4'h0;
        else             a_state <= fsm_next(a_state, a_sig);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      b_state <= 4'h0;
        else if (b_clr)  b_state <= 4'h0;
        else             b_state <= fsm_next(b_state, b_sig);
    end

    fsm_bist_engine u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bist_start_i (start),
        .bist_abort_i (abort),
        .func_sig_i   (func),
        .state_i      (d_state),
        .sig_o        (d_sig),
        .fsm_clr_o    (d_clr),
        .busy_o       (d_busy),
        .done_o       (d_done),
        .pass_o       (d_pass),
        .signature_o  (d_sigr)
    );

    fsm_bist_engine #(
        .N_PATTERNS (1),
        .LFSR_SEED  (8'h01),
        .GOLDEN_SIG (16'h0002)
    ) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .bist_start_i (start),
        .bist_abort_i (abort),
        .func_sig_i   (func),
        .state_i      (a_state),
        .sig_o        (a_sig),
        .fsm_clr_o    (a_clr),
        .busy_o       (a_busy),
        .done_o       (a_done),
        .pass_o       (a_pass),
        .signature_o  (a_sigr)
    );

    fsm_bist_engine #(
        .N_PATTERNS (1),
        .LFSR_SEED  (8'hA5),
        .GOLDEN_SIG (16'h0002)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .bist_start_i (start),
        .bist_abort_i (abort),
        .func_sig_i   (func),
        .state_i      (b_state),
        .sig_o        (b_sig),
        .fsm_clr_o    (b_clr),
        .busy_o       (b_busy),
        .done_o       (b_done),
        .pass_o       (b_pass),
        .signature_o  (b_sigr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after edge 0 (the edge that samples start).
    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_sig_o"}, 32'(d_sig), 32'(func));
        check_eq({tag, "_clr"},   32'(d_clr), 32'd0);
        check_eq({tag, "_busy"},  32'(d_busy), 32'd0);
        check_eq({tag, "_done"},  32'(d_done), 32'd0);
        check_eq({tag, "_pass"},  32'(d_pass), 32'd0);
        check_eq({tag, "_sigr"},  32'(d_sigr), 32'd0);
    endtask

    initial begin
        full_ref = ref_sig(255, 8'hA5, 256);

        // Reset values
        repeat (2) tick();
        check_idle_outputs("rst");
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_rst");

        // Short tests (u_dut_a / u_dut_b) plus default test in parallel
        start_pulse();
        tick();                                          // cycle 1
        check_eq("a_init_clr",  32'(a_clr), 32'd1);
        check_eq("a_init_busy", 32'(a_busy), 32'd1);
        tick();                                          // cycle 2
        check_eq("a_run_sig",   32'(a_sig), 32'h1);
        check_eq("b_run_sig",   32'(b_sig), 32'h5);
        check_eq("a_run_clr",   32'(a_clr), 32'd0);
        tick();                                          // cycle 3, drain
        check_eq("a_drain_sig",  32'(a_sig), 32'h0);
        check_eq("a_drain_done", 32'(a_done), 32'd0);
        tick();                                          // after edge 4
        check_eq("a_done",  32'(a_done), 32'd1);
        check_eq("a_sigr",  32'(a_sigr), 32'h0002);
        check_eq("a_pass",  32'(a_pass), 32'd1);
        check_eq("a_busy",  32'(a_busy), 32'd0);
        check_eq("a_func",  32'(a_sig), 32'h9);
        check_eq("b_done",  32'(b_done), 32'd1);
        check_eq("b_sigr",  32'(b_sigr), 32'h0000);
        check_eq("b_pass",  32'(b_pass), 32'd0);

        repeat (253) tick();                             // cycle 257
        check_eq("d_done_early", 32'(d_done), 32'd0);
        check_eq("d_busy_257",   32'(d_busy), 32'd1);
        tick();                                          // after edge 258
        check_eq("d_done",  32'(d_done), 32'd1);
        check_eq("d_sigr",  32'(d_sigr), 32'(full_ref));
        check_eq("d_pass",  32'(d_pass), 32'(full_ref == 16'h0000));
        check_eq("d_func",  32'(d_sig), 32'h9);
        tick();
        check_eq("d_done_hold", 32'(d_done), 32'd1);

        // Restart from DONE, abort in RUN cycle 50
        func = 4'h3;
        start_pulse();
        check_eq("d_done_before_init", 32'(d_done), 32'd1);
        tick();                                          // cycle 1
        check_eq("restart_done_drop", 32'(d_done), 32'd0);
        check_eq("restart_busy",      32'(d_busy), 32'd1);
        repeat (49) tick();                              // cycle 50
        check_eq("run50_busy", 32'(d_busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy",  32'(d_busy), 32'd0);
        check_eq("abort_done",  32'(d_done), 32'd0);
        check_eq("abort_pass",  32'(d_pass), 32'd0);
        check_eq("abort_sig_o", 32'(d_sig), 32'h3);
        check_eq("abort_sigr",  32'(d_sigr), 32'(ref_sig(255, 8'hA5, 49)));
        repeat (3) tick();
        check_eq("abort_stays_idle", 32'(d_busy), 32'd0);

        // New start after abort completes normally
        start_pulse();
        repeat (257) tick();
        check_eq("re_done_early", 32'(d_done), 32'd0);
        tick();
        check_eq("re_done", 32'(d_done), 32'd1);
        check_eq("re_sigr", 32'(d_sigr), 32'(full_ref));

        // Start held high, reset mid-RUN
        func = 4'h6;
        start = 1'b1;
        repeat (100) tick();
        check_eq("held_busy_mid", 32'(d_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        tick();
        check_idle_outputs("midrst_hold");
        rst_n = 1'b1;
        tick();                                          // edge 0 samples start
        busy_gaps  = 0;
        clr_cycles = 0;
        for (int i = 1; i <= 257; i++) begin
            tick();
            if (!d_busy) busy_gaps++;
            if (d_clr) clr_cycles++;
        end
        check_eq("held_busy_gaps",  32'(busy_gaps), 32'd0);
        check_eq("held_clr_cycles", 32'(clr_cycles), 32'd1);
        tick();                                          // after edge 258
        check_eq("held_done", 32'(d_done), 32'd1);
        check_eq("held_sigr", 32'(d_sigr), 32'(full_ref));
        start = 1'b0;
        repeat (2) tick();
        check_eq("held_done_hold", 32'(d_done), 32'd1);
        check_eq("held_no_busy",   32'(d_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_bist_engine.md
# fsm_bist_engine

Built-in self-test initiator for the 4-bit Moore FSM (`fsm_mur`) in the JTAG test path. On a start pulse from the TAP-side logic, the block takes over the FSM's 4-bit input bus and clears the FSM state. It then drives a pseudo-random pattern sequence into the FSM, compacts the FSM's state responses into a 16-bit MISR signature, and reports done/pass. Outside a test, the block passes functional inputs through to the FSM untouched.

## Interface
- `N_PATTERNS`, 255: number of patterns applied, 1..65535
- `LFSR_SEED`, 8'hA5: pattern LFSR seed, nonzero
- `GOLDEN_SIG`, 16'h0000: expected signature; set per build from the bench model
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous active-low reset (one clock; reset is asynchronous and active-low)
- `bist_start_i` input 1: start pulse, sampled on `clk`
- `bist_abort_i` input 1: abort request, sampled on `clk`
- `func_sig_i` input 4: functional FSM input, used when not busy
- `state_i` input 4: FSM `state_o`
- `sig_o` output 4: FSM `sig_in`
- `fsm_clr_o` output 1: drives FSM `start_bist` and clears the FSM state
- `busy_o` output 1: test in progress
- `done_o` output 1: test complete, held until the next start or an abort
- `pass_o` output 1: signature matched, valid while `done_o`=1
- `signature_o` output 16: MISR contents

## Operation
- States: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE/DONE → INIT on `bist_start_i`=1.
- INIT: `fsm_clr_o`=1 for one cycle; LFSR ← `LFSR_SEED`; MISR ← 0; pattern counter ← 0; `done_o`, `pass_o` ← 0. Next state is RUN.
- RUN:
  - `sig_o` = `lfsr[3:0]`.
  - LFSR shifts every cycle: `lfsr_next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}` (maximal, period 255).
  - Counter increments every cycle.
  - Go to DRAIN when counter = `N_PATTERNS`-1.
- DRAIN: one cycle; `sig_o` = 4'h0; next state is DONE.
- DONE: `done_o`=1; `pass_o` = (MISR == `GOLDEN_SIG`), registered on DONE entry.
- MISR updates in every RUN and DRAIN cycle, for `N_PATTERNS`+1 updates in total:
  - `shifted = {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 16'h0)`
  - `misr_next = shifted ^ {12'h0, state_i}`
  - The first update absorbs the cleared state 4'h0. The last update absorbs the FSM's response to the final pattern.
- `sig_o` = `busy_o` ? engine pattern : `func_sig_i`. This mux is combinational.
- `busy_o` = 1 in INIT, RUN and DRAIN.
- `bist_start_i` is ignored while busy.
- `bist_abort_i` in any state → IDLE next cycle:
  - `done_o`, `pass_o` ← 0.
  - `signature_o` keeps its partial value.
  - Abort takes priority over start when both are asserted.
- FSM state after a test is left as-is. Functional users must clear it themselves.
- The counter is `$clog2(N_PATTERNS+1)` bits wide and never wraps.

## Timing
- Reset values: state IDLE; `fsm_clr_o`, `busy_o`, `done_o`, `pass_o` = 0; `signature_o` = 16'h0; LFSR = `LFSR_SEED`. `sig_o` follows `func_sig_i`.
- Cycle numbering: start is sampled at edge 0.
  - INIT occupies cycle 1.
  - RUN occupies cycles 2..`N_PATTERNS`+1.
  - DRAIN occupies cycle `N_PATTERNS`+2.
  - `done_o` rises at edge `N_PATTERNS`+3.
- FSM latency is one cycle: the pattern driven in cycle k appears on `state_i` in cycle k+1. DRAIN exists to capture the last response.
- Reset mid-test: immediate return to the reset values above; no partial `done_o`.
- A start in DONE restarts at INIT on the next edge. `done_o` drops in that same cycle.

## Structure
- `fsm_bist_pkg`:
  - state enum `bist_state_e`
  - `MISR_POLY` = 16'h1021
  - `LFSR_TAPS` constant
  - `MISR_W` = 16
- Sub-module `bist_misr16`: clear, enable and 4-bit data inputs; 16-bit signature output. Instantiated once.
- The LFSR, counter and FSM stay in the top module.

## Test plan
- Reset, then `func_sig_i`=4'h9 → `sig_o`=4'h9, all flags 0, `signature_o`=0.
- `N_PATTERNS`=1, `LFSR_SEED`=8'h01, start pulse:
  - Cycle 1: `fsm_clr_o`=1.
  - Cycle 2: `sig_o`=4'h1.
  - FSM goes 0→2.
  - `signature_o`=16'h0002; `done_o`=1 at edge 4.
  - With `GOLDEN_SIG`=16'h0002, `pass_o`=1.
- `N_PATTERNS`=1, `LFSR_SEED`=8'hA5: pattern 4'h5 keeps the FSM at 0 → `signature_o`=16'h0000. With `GOLDEN_SIG`=16'h0002, `pass_o`=0.
- Default parameters, start → `done_o` at edge 258; signature equals the bench reference model of FSM, LFSR and MISR.
- Abort in RUN cycle 50 → IDLE next cycle; `done_o`=0; `sig_o` reverts to `func_sig_i`. A new start then completes normally.
- Start held high throughout, then `rst_n` low mid-RUN → all outputs return to reset values. After release with start still high: a single test runs, and no restart occurs while busy.
